// File: rtl/countdown_pkg.sv
// Shared definitions for the cascaded countdown timer: FSM states,
// digit geometry and the counter-width helper.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSED = 2'd3
    } state_e;

    localparam int DIGIT_W    = 4;
    localparam int MOD_BINARY = 16;
    localparam int MOD_BCD    = 10;

    function automatic int count_width(input int stages);
        return DIGIT_W * stages;
    endfunction

endpackage

// File: rtl/down_digit.sv
// One 4-bit down-counting digit stage with load clamping and borrow-in;
// wraps from 0 to MODULUS-1 when a borrow reaches it.
module down_digit
    import countdown_pkg::*;
#(
    parameter int MODULUS = MOD_BINARY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_digit_i,
    input  logic               en_i,
    input  logic               borrow_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               is_zero_o
);

    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = DIGIT_W'(MODULUS - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_ZERO = {DIGIT_W{1'b0}};

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] r;
        if (d > DIGIT_MAX) begin
            r = DIGIT_MAX;
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    // Next digit value: a load takes priority over any decrement.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = clamp_digit(load_digit_i);
        end else if (en_i && borrow_i) begin
            if (digit_q == DIGIT_ZERO) begin
                digit_d = DIGIT_MAX;
            end else begin
                digit_d = digit_q - DIGIT_W'(1);
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= DIGIT_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o   = digit_q;
    assign is_zero_o = (digit_q == DIGIT_ZERO);

endmodule

// File: rtl/countdown_timer.sv
// Loadable cascaded down-counter (binary or BCD digits) with a valid/ready
// load port, start/pause control and a registered done pulse at zero.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter  int STAGES  = 4,
    parameter  int MODULUS = MOD_BINARY,
    localparam int W       = count_width(STAGES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_value,
    input  logic         start,
    input  logic         pause,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         done
);

    state_e            state_q;
    state_e            state_d;
    logic              done_q;
    logic              done_d;
    logic              dec_en_s;
    logic              load_fire_s;
    logic              count_zero_s;
    logic              count_one_s;
    logic [STAGES-1:0] is_zero_s;
    logic [STAGES-1:0] borrow_s;

    // load_ready and busy depend on the state register only.
    assign load_ready   = (state_q == ST_IDLE) || (state_q == ST_LOADED);
    assign busy         = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign load_fire_s  = load_valid && load_ready;
    assign count_zero_s = &is_zero_s;
    assign count_one_s  = (count == W'(1));

    // Next-state, done and decrement-enable decode.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        dec_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_fire_s) begin
                    state_d = ST_LOADED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOADED: begin
                if (load_fire_s) begin
                    state_d = ST_LOADED;
                end else if (start) begin
                    if (count_zero_s) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_LOADED;
                end
            end
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_PAUSED;
                end else if (count_zero_s) begin
                    // Unreachable in normal operation; never let the counter wrap.
                    state_d = ST_IDLE;
                end else begin
                    dec_en_s = 1'b1;
                    if (count_one_s) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_PAUSED: begin
                if (start && !pause) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and done registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign done        = done_q;
    assign borrow_s[0] = 1'b1;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_digit
        if (k > 0) begin : g_borrow
            assign borrow_s[k] = borrow_s[k-1] && is_zero_s[k-1];
        end

        down_digit #(
            .MODULUS(MODULUS)
        ) u_digit (
            .clk         (clk),
            .reset       (reset),
            .load_i      (load_fire_s),
            .load_digit_i(load_value[DIGIT_W*k +: DIGIT_W]),
            .en_i        (dec_en_s),
            .borrow_i    (borrow_s[k]),
            .digit_o     (count[DIGIT_W*k +: DIGIT_W]),
            .is_zero_o   (is_zero_s[k])
        );
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: a binary 1-digit timer and a BCD 2-digit timer driven by
// directed vectors; expected post-edge outputs are queued and checked by a monitor.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       lv_a = 1'b0, st_a = 1'b0, pa_a = 1'b0;
    logic [3:0] val_a = 4'h0;
    logic       rdy_a, busy_a, done_a;
    logic [3:0] count_a;

    logic       lv_b = 1'b0, st_b = 1'b0, pa_b = 1'b0;
    logic [7:0] val_b = 8'h00;
    logic       rdy_b, busy_b, done_b;
    logic [7:0] count_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         dut;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       ready;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    event probe_ev;

    always #5 clk = ~clk;

    countdown_timer #(.STAGES(1), .MODULUS(16)) u_bin (
        .clk(clk), .reset(reset), .load_valid(lv_a), .load_ready(rdy_a),
        .load_value(val_a), .start(st_a), .pause(pa_a),
        .count(count_a), .busy(busy_a), .done(done_a)
    );

    countdown_timer #(.STAGES(2), .MODULUS(10)) u_bcd (
        .clk(clk), .reset(reset), .load_valid(lv_b), .load_ready(rdy_b),
        .load_value(val_b), .start(st_b), .pause(pa_b),
        .count(count_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] ec, input logic eb,
                        input logic ed, input logic er, input string nm);
        exp_t e;
        e.dut = d; e.cnt = ec; e.busy = eb; e.done = ed; e.ready = er; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic step(input int d, input logic lv, input logic [7:0] v,
                        input logic st, input logic pa, input logic [7:0] ec,
                        input logic eb, input logic ed, input logic er, input string nm);
        @(negedge clk);
        if (d == 0) begin
            lv_a = lv; val_a = v[3:0]; st_a = st; pa_a = pa;
        end else begin
            lv_b = lv; val_b = v; st_b = st; pa_b = pa;
        end
        push(d, ec, eb, ed, er, nm);
    endtask

    // Monitor: compare every queued expectation against the sampled outputs.
    initial begin
        exp_t       e;
        logic [7:0] c;
        logic       b, dn, r;
        forever begin
            @(posedge clk or probe_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.dut == 0) begin
                    c = {4'h0, count_a}; b = busy_a; dn = done_a; r = rdy_a;
                end else begin
                    c = count_b; b = busy_b; dn = done_b; r = rdy_b;
                end
                chk({e.nm, ".count"}, c, e.cnt);
                chk({e.nm, ".busy"}, 8'(b), 8'(e.busy));
                chk({e.nm, ".done"}, 8'(dn), 8'(e.done));
                chk({e.nm, ".load_ready"}, 8'(r), 8'(e.ready));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #3;
        push(0, 8'h00, 1'b0, 1'b0, 1'b1, "reset_bin");
        push(1, 8'h00, 1'b0, 1'b0, 1'b1, "reset_bcd");
        -> probe_ev;
        @(negedge clk);
        reset = 1'b0;

        // Binary single digit: 3 -> 2 -> 1 -> 0
        step(0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, "bin_load");
        step(0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, "bin_start");
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, "bin_2");
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, "bin_1");
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "bin_0_done");
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "bin_after1");
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "bin_after2");

        // BCD clamp, reload-with-start, then 20 -> 0 with loads offered mid-run
        step(1, 1'b1, 8'hAF, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, "bcd_clamp");
        step(1, 1'b1, 8'h20, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1, "ld_start_same");
        step(1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, "bcd_start");
        for (int k = 1; k <= 20; k++) begin
            n = 20 - k;
            step(1, (k <= 10), 8'h55, 1'b0, 1'b0, to_bcd(n), (n != 0), (n == 0), (n == 0),
                 $sformatf("bcd_run%0d", k));
        end
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "bcd_after");

        // Pause at 03 for three sampled edges (one with start also high)
        step(1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b1, "p_load");
        step(1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, "p_start");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, "p_4");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, "p_3");
        step(1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, "p_pause1");
        step(1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, "p_pause_prio");
        step(1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, "p_pause3");
        step(1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, "p_resume");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, "p_2");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, "p_1");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "p_done");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "p_after");

        // Zero start: immediate done, busy never set, start ignored in IDLE
        step(1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "z_load");
        step(1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "z_start");
        step(1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "z_idle_start");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "z_idle");

        // Asynchronous reset mid-run at 07
        step(1, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1, "r_load");
        step(1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, "r_start");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0, "r_9");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, "r_8");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, "r_7");
        @(posedge clk);
        #3;
        reset = 1'b1;
        push(1, 8'h00, 1'b0, 1'b0, 1'b1, "r_async");
        -> probe_ev;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "r_no_done1");
        step(1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "r_no_done2");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
